mirfak_clint: RTL
=================

// Module: mirfak_clint
// PURPOSE
//  Core-local interruptor: memory-mapped machine timer (mtime/mtimecmp) and software-interrupt (msip) registers on a Wishbone slave port.
//  Sits directly upstream of the CSR unit: xint_mtip_o and xint_msip_o drive the CSR xint_mtip_i / xint_msip_i inputs (mip.MTIP / mip.MSIP).
//  Single hart. 64-bit mtime is also exported for an optional time/timeh CSR shadow.
// PARAMETERS
//  PRESCALER   32'd1   clk_i cycles per mtime increment; must be >= 1; 1 = increment every cycle
//  MTIME_RST   64'd0   mtime value after reset
// PORTS
//  clk_i          in   1   clock; all logic on posedge
//  rst_i          in   1   reset; asynchronous, active-high
//  wbs_addr_i     in   5   byte address within block; bits [1:0] ignored
//  wbs_dat_i      in   32  write data
//  wbs_sel_i      in   4   byte enables for writes
//  wbs_cyc_i      in   1   bus cycle
//  wbs_stb_i      in   1   strobe
//  wbs_we_i       in   1   1 = write, 0 = read
//  wbs_dat_o      out  32  read data; valid while wbs_ack_o = 1
//  wbs_ack_o      out  1   transfer done (one-cycle pulse)
//  wbs_err_o      out  1   unmapped address (one-cycle pulse, instead of ack)
//  xint_mtip_o    out  1   timer interrupt pending, to CSR
//  xint_msip_o    out  1   software interrupt pending, to CSR
//  mtime_o        out  64  current mtime value
// BEHAVIOUR
//  Register map (word offsets): 0x00 MSIP (bit0 r/w, bits 31:1 read 0), 0x04 MTIMECMP[31:0], 0x08 MTIMECMP[63:32],
//   0x0C MTIME[31:0], 0x10 MTIME[63:32]; 0x14-0x1C unmapped.
//  Reset values: mtime = MTIME_RST, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescale count = 0,
//   wbs_ack_o = wbs_err_o = 0, wbs_dat_o = 0, xint_mtip_o = xint_msip_o = 0.
//  Reset asserted mid-transfer aborts the transfer: no ack/err is issued, and the master must restart.
//  Bus handshake: request = cyc & stb & !ack & !err. A request registers ack (mapped) or err (unmapped) one cycle later.
//   The strobe must be held until ack/err. Ack/err is high for exactly one cycle, so back-to-back requests
//   complete every 2 cycles. Writes commit on the request cycle edge (the same edge that raises ack).
//   Read data is captured on that edge and returned with ack. wbs_dat_o = 0 on err. Writes honour wbs_sel_i per byte.
//   sel = 0 writes nothing but still acks.
//  Prescaler: counter 0..PRESCALER-1. tick = (count == PRESCALER-1). On tick, count -> 0 and mtime <= mtime + 1.
//   mtime is 64-bit and wraps FFFF_FFFF_FFFF_FFFF -> 0 with no flag.
//  Simultaneous bus write to an MTIME half and tick: the written half takes the bus data (byte-merged with the old value).
//   The other half keeps its pre-tick value, so the increment is dropped that cycle. The prescaler still advances/wraps normally.
//   There is no carry between halves from a write.
//  Reads of MTIME return the pre-edge value. The low-to-high read tear is software's responsibility (read hi, lo, hi).
//  xint_mtip_o: registered, = (mtime >= mtimecmp) evaluated on the register values after the update.
//   The output follows one cycle after mtime or mtimecmp changes. Unsigned 64-bit compare.
//   Level output, cleared only by writing mtimecmp > mtime.
//  xint_msip_o = msip bit0 register (already registered; updates on the write edge).
//  Registers change only via the bus or the timer; no other side effects on read.
// TESTING
//  1) Reset with PRESCALER=1 -> mtime_o counts 0,1,2.. each cycle; mtip=0, msip=0; read 0x08 -> 32'hFFFF_FFFF.
//  2) Write MTIMECMP lo=0x20, hi=0 while mtime<0x20 -> mtip=0; mtip rises exactly 1 cycle after mtime_o==0x20.
//     Then write hi=1 -> mtip falls 1 cycle later.
//  3) Write MSIP=1 -> xint_msip_o=1 on the ack cycle; read 0x00 -> 0x1.
//     Write 0xFFFF_FFFE -> msip=0; read returns 0.
//  4) PRESCALER=4: mtime increments every 4th cycle.
//     MTIME lo write of 0xFFFF_FFFF with hi=0 -> after the next tick, lo=0 and hi=1 (carry).
//     Set mtime=all-ones -> wraps to 0.
//  5) Write MTIME lo=0x100 with sel=4'b0001 on a tick cycle -> lo = {old[31:8],8'h00}; no increment that cycle.
//  6) Access 0x14 -> err pulse, no ack, dat_o=0. Assert rst_i mid-request -> ack/err stay 0 and registers return to reset values immediately.

Source files
------------

// File: rtl/mirfak_clint.sv
`default_nettype none
// ============================================================================
// Module   : mirfak_clint
// Purpose  : Core-local interruptor for a single hart. Provides the 64-bit
//            machine timer (mtime), its compare register (mtimecmp) and the
//            software-interrupt bit (msip) on a Wishbone slave port. The
//            interrupt outputs feed the CSR unit's mip.MTIP / mip.MSIP.
// Ports    : clk_i, rst_i (async, active-high)
//            wbs_addr_i/dat_i/sel_i/cyc_i/stb_i/we_i  - Wishbone request
//            wbs_dat_o/ack_o/err_o                    - Wishbone response
//            xint_mtip_o, xint_msip_o                 - interrupt pending
//            mtime_o                                  - live mtime value
// Map      : 0x00 MSIP, 0x04 MTIMECMP lo, 0x08 MTIMECMP hi,
//            0x0C MTIME lo, 0x10 MTIME hi, 0x14-0x1C unmapped (err)
// Revision : 1.0 - initial release
// ============================================================================
module mirfak_clint #(
    parameter logic [31:0] PRESCALER = 32'd1,
    parameter logic [63:0] MTIME_RST = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o,
    output logic [63:0] mtime_o
);

    localparam logic [2:0]  c_IDX_MSIP   = 3'd0;
    localparam logic [2:0]  c_IDX_CMP_LO = 3'd1;
    localparam logic [2:0]  c_IDX_CMP_HI = 3'd2;
    localparam logic [2:0]  c_IDX_MT_LO  = 3'd3;
    localparam logic [2:0]  c_IDX_MT_HI  = 3'd4;
    localparam logic [63:0] c_CMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_mtip;
    logic [31:0] r_count;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;

    logic        w_req;
    logic [2:0]  w_idx;
    logic        w_mapped;
    logic        w_wr;
    logic        w_tick;
    logic [31:0] w_rdata;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_cmp_nxt;
    logic        w_msip_nxt;
    logic        w_unused_addr;

    // Byte-lane write merge: lanes without a select bit keep the old value.
    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Word addressing only; the two byte-offset bits carry no meaning.
    assign w_unused_addr = ^wbs_addr_i[1:0];

    // A request is only seen while no response is outstanding, which makes
    // every transfer take exactly two cycles (request, ack/err).
    assign w_req    = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;
    assign w_idx    = wbs_addr_i[4:2];
    assign w_mapped = (w_idx <= c_IDX_MT_HI);
    assign w_wr     = w_req & w_mapped & wbs_we_i;
    assign w_tick   = (r_count == (PRESCALER - 32'd1));

    // Read mux works on the pre-edge register values.
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            c_IDX_MSIP:   w_rdata = {31'd0, r_msip};
            c_IDX_CMP_LO: w_rdata = r_mtimecmp[31:0];
            c_IDX_CMP_HI: w_rdata = r_mtimecmp[63:32];
            c_IDX_MT_LO:  w_rdata = r_mtime[31:0];
            c_IDX_MT_HI:  w_rdata = r_mtime[63:32];
            default:      w_rdata = 32'd0;
        endcase
    end

    // Next-state for the architectural registers. A bus write to either
    // mtime half overrides the timer increment for the whole 64-bit value:
    // the untouched half keeps its old value and no carry crosses halves.
    always_comb begin
        w_mtime_nxt = w_tick ? (r_mtime + 64'd1) : r_mtime;
        w_cmp_nxt   = r_mtimecmp;
        w_msip_nxt  = r_msip;
        if (w_wr) begin
            case (w_idx)
                c_IDX_MSIP: begin
                    if (wbs_sel_i[0]) begin
                        w_msip_nxt = wbs_dat_i[0];
                    end
                end
                c_IDX_CMP_LO: w_cmp_nxt[31:0]  = f_merge(r_mtimecmp[31:0],  wbs_dat_i, wbs_sel_i);
                c_IDX_CMP_HI: w_cmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
                c_IDX_MT_LO:  w_mtime_nxt = {r_mtime[63:32], f_merge(r_mtime[31:0], wbs_dat_i, wbs_sel_i)};
                c_IDX_MT_HI:  w_mtime_nxt = {f_merge(r_mtime[63:32], wbs_dat_i, wbs_sel_i), r_mtime[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mtime    <= MTIME_RST;
            r_mtimecmp <= c_CMP_RST;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_count    <= 32'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= 32'd0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_cmp_nxt;
            r_msip     <= w_msip_nxt;
            // Compare the registers as they currently stand, so the pending
            // flag trails any mtime/mtimecmp change by one cycle.
            r_mtip     <= (r_mtime >= r_mtimecmp);
            r_count    <= w_tick ? 32'd0 : (r_count + 32'd1);
            r_ack      <= w_req & w_mapped;
            r_err      <= w_req & ~w_mapped;
            r_dat      <= (w_req & w_mapped & ~wbs_we_i) ? w_rdata : 32'd0;
        end
    end

    assign wbs_dat_o   = r_dat;
    assign wbs_ack_o   = r_ack;
    assign wbs_err_o   = r_err;
    assign xint_mtip_o = r_mtip;
    assign xint_msip_o = r_msip;
    assign mtime_o     = r_mtime;

endmodule
`default_nettype wire
